food_placer: RTL and testbench
==============================

// Module: food_placer
// PURPOSE
//   Consumes the free-running pseudo-random (x,y) pair (each 0..9) from the grid LFSR and
//   places a food item on an unoccupied cell of the 10x10 game grid.
//   On request: sample random coordinates, query the occupancy map, and retry on a hit.
//   After MAX_TRIES misses, fall back to a deterministic raster scan.
//   Sits between the LFSR and the game-state/VGA renderer.
// PARAMETERS
//   GRID_W     10  grid columns; valid x = 0..GRID_W-1
//   GRID_H     10  grid rows; valid y = 0..GRID_H-1
//   COORD_W    4   coordinate width, all x/y ports
//   MAX_TRIES  8   random attempts before raster-scan fallback (1..255)
// PORTS
//   clk         in   1        system clock, all logic posedge
//   rst_n       in   1        asynchronous active-low reset
//   place_req   in   1        1-cycle pulse: place new food; ignored while busy=1
//   rand_x      in   COORD_W  LFSR x output, advances every clk
//   rand_y      in   COORD_W  LFSR y output, advances every clk
//   occ_x       out  COORD_W  occupancy-map query column
//   occ_y       out  COORD_W  occupancy-map query row
//   occ_hit     in   1        cell (occ_x,occ_y) occupied; valid exactly 1 cycle after occ_x/y driven
//   food_x      out  COORD_W  placed food column, held until next successful placement
//   food_y      out  COORD_W  placed food row
//   food_valid  out  1        food_x/y hold a legal placement
//   busy        out  1        placement in progress
//   done        out  1        1-cycle pulse: placement finished (success or grid_full)
//   grid_full   out  1        last request found no free cell; cleared by next place_req
// BEHAVIOUR
//   Reset (async, any state): state IDLE, food_x/y=0, food_valid=0, busy=0, done=0, grid_full=0,
//     occ_x/y=0, try counter=0. Reset during a placement aborts it; no done pulse.
//   FSM states: IDLE, SAMPLE, LOOKUP, CHECK, SCAN_Q, SCAN_CHK, FINISH.
//   IDLE:     place_req=1 -> SAMPLE; busy=1 from the next cycle; grid_full cleared; tries=0.
//   SAMPLE:   latch rand_x/y into cand. If cand_x>=GRID_W or cand_y>=GRID_H, count as a miss
//             (tries+1, no query). Otherwise drive occ_x/y=cand -> LOOKUP.
//   LOOKUP:   hold occ_x/y (1 wait cycle for map latency) -> CHECK.
//   CHECK:    occ_hit=0 -> commit cand -> FINISH.
//             occ_hit=1 -> tries+1; tries==MAX_TRIES -> SCAN_Q (scan starts at last cand, wrapped
//             into range), else -> SAMPLE.
//   SCAN_Q:   drive occ_x/y=scan pos -> SCAN_CHK (occ_hit sampled in SCAN_CHK).
//   SCAN_CHK: occ_hit=0 -> commit scan pos -> FINISH. Otherwise advance raster:
//             x+1; at GRID_W-1 wrap x=0, y+1; at (GRID_W-1,GRID_H-1) wrap to (0,0).
//             After GRID_W*GRID_H cells visited with no free cell: grid_full=1 -> FINISH without
//             commit; food_x/y keep old value; food_valid=0.
//   FINISH:   done=1 for one cycle; busy=0 the following cycle -> IDLE.
//   Commit: food_x/y <= cand, food_valid <= 1; updated in the same edge that enters FINISH.
//   Latency on first-try success: place_req(edge0) -> SAMPLE -> LOOKUP -> CHECK -> FINISH;
//     done high in the 4th cycle after the req edge.
//   Each retry costs 3 cycles. Consecutive samples are distinct LFSR states, since the LFSR steps
//     every clk.
//   place_req while busy: dropped; no queueing.
//   place_req in the same cycle as done: dropped (busy still 1).
//   occ_hit is ignored outside CHECK/SCAN_CHK.
//   Scan visit counter width: clog2(GRID_W*GRID_H)+1; no overflow at 100.
// STRUCTURE
//   game_pkg: GRID_W, GRID_H, COORD_W constants and the placer_state_t enum; shared with the
//     LFSR and renderer.
//   Sub-module grid_scan_counter: x/y raster counter with load, step, wrap and visited-count
//     outputs (all_visited).
//   Registered outputs only; no combinational path from occ_hit to any output.
// TESTING
//   1 Reset mid-LOOKUP with occ_hit=0 -> busy=0, food_valid=0, no done; next req places normally.
//   2 Empty map (occ_hit=0), rand=(3,7), req -> done in cycle 4; food=(3,7); food_valid=1.
//   3 occ_hit=1 for the first 2 lookups, then 0 -> 3 distinct samples queried; food = 3rd sample;
//     done in cycle 10.
//   4 Map full except (9,9); model returns hit for all else; MAX_TRIES=8 -> scan wraps;
//     food=(9,9); food_valid=1.
//   5 Map fully occupied -> grid_full=1, done pulse after 100 scan cells, food_valid=0,
//     food_x/y unchanged.
//   6 place_req pulsed each cycle while busy -> exactly one done; rand_x=12 injected
//     -> counted as miss, never queried.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, placer state encoding and a small coordinate helper
// used by the food placer, the grid LFSR and the renderer.
package game_pkg;

  localparam int GRID_W     = 10;
  localparam int GRID_H     = 10;
  localparam int COORD_W    = 4;
  localparam int GRID_CELLS = GRID_W * GRID_H;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    LOOKUP,
    CHECK,
    SCAN_Q,
    SCAN_CHK,
    FINISH
  } placer_state_t;

  // Folds a 4-bit LFSR coordinate (0..15) back into 0..lim-1.
  function automatic logic [COORD_W-1:0] wrap_coord(input logic [COORD_W-1:0] v,
                                                    input logic [COORD_W-1:0] lim);
    return (v >= lim) ? v - lim : v;
  endfunction

endpackage

// File: rtl/grid_scan_counter.sv
// Raster position counter over the game grid with load, step and wrap, plus a
// visit count that flags the last not-yet-visited cell of a full sweep.
module grid_scan_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [COORD_W-1:0] next_x,
  output logic [COORD_W-1:0] next_y,
  output logic               last_cell
);

  localparam int VISIT_W = $clog2(GRID_CELLS) + 1;
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_H - 1);
  localparam logic [VISIT_W-1:0] CNT_LAST = VISIT_W'(GRID_CELLS - 1);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [VISIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    if (load) begin
      x_d   = load_x;
      y_d   = load_y;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign pos_x     = x_q;
  assign pos_y     = y_q;
  assign next_x    = x_d;
  assign next_y    = y_d;
  // Count holds cells already stepped past, so GRID_CELLS-1 means the final cell.
  assign last_cell = (cnt_q == CNT_LAST);

endmodule

// File: rtl/food_placer.sv
// Places food on a free grid cell: random LFSR samples checked against the
// occupancy map, falling back to a raster scan after MAX_TRIES misses.
module food_placer
  import game_pkg::*;
#(
  parameter int MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               place_req,
  input  logic [COORD_W-1:0] rand_x,
  input  logic [COORD_W-1:0] rand_y,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_hit,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               busy,
  output logic               done,
  output logic               grid_full
);

  localparam logic [7:0]         TRIES_MAX = 8'(MAX_TRIES);
  localparam logic [COORD_W-1:0] W_LIM     = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] H_LIM     = COORD_W'(GRID_H);

  placer_state_t      state_q, state_d;
  logic [7:0]         tries_q, tries_d;
  logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [COORD_W-1:0] occ_x_q, occ_x_d, occ_y_q, occ_y_d;
  logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
  logic               food_valid_q, food_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               grid_full_q, grid_full_d;

  logic               scan_load, scan_step, scan_last;
  logic [COORD_W-1:0] scan_x, scan_y, scan_nx, scan_ny;
  logic               rand_oob;

  assign rand_oob = (rand_x >= W_LIM) || (rand_y >= H_LIM);

  grid_scan_counter u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (scan_load),
    .step      (scan_step),
    .load_x    (wrap_coord(cand_x_d, W_LIM)),
    .load_y    (wrap_coord(cand_y_d, H_LIM)),
    .pos_x     (scan_x),
    .pos_y     (scan_y),
    .next_x    (scan_nx),
    .next_y    (scan_ny),
    .last_cell (scan_last)
  );

  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    grid_full_d  = grid_full_q;
    scan_load    = 1'b0;
    scan_step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (place_req) begin
          state_d     = SAMPLE;
          grid_full_d = 1'b0;
          tries_d     = '0;
        end
      end
      SAMPLE: begin
        cand_x_d = rand_x;
        cand_y_d = rand_y;
        if (rand_oob) begin
          tries_d = tries_q + 1'b1;
          if (tries_d == TRIES_MAX) begin
            state_d   = SCAN_Q;
            scan_load = 1'b1;
          end
        end else begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (!occ_hit) begin
          food_x_d     = cand_x_q;
          food_y_d     = cand_y_q;
          food_valid_d = 1'b1;
          state_d      = FINISH;
        end else begin
          tries_d = tries_q + 1'b1;
          if (tries_d == TRIES_MAX) begin
            state_d   = SCAN_Q;
            scan_load = 1'b1;
          end else begin
            state_d = SAMPLE;
          end
        end
      end
      SCAN_Q: state_d = SCAN_CHK;
      SCAN_CHK: begin
        if (!occ_hit) begin
          food_x_d     = scan_x;
          food_y_d     = scan_y;
          food_valid_d = 1'b1;
          state_d      = FINISH;
        end else if (scan_last) begin
          grid_full_d  = 1'b1;
          food_valid_d = 1'b0;
          state_d      = FINISH;
        end else begin
          scan_step = 1'b1;
          state_d   = SCAN_Q;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == FINISH);
    busy_d = (state_d != IDLE);
  end

  // The query address is registered on the edge entering the wait state so the
  // map answer lands exactly when CHECK / SCAN_CHK evaluates it.
  always_comb begin
    occ_x_d = occ_x_q;
    occ_y_d = occ_y_q;
    if (state_d == LOOKUP) begin
      occ_x_d = cand_x_d;
      occ_y_d = cand_y_d;
    end else if (state_d == SCAN_Q) begin
      occ_x_d = scan_nx;
      occ_y_d = scan_ny;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tries_q      <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      occ_x_q      <= '0;
      occ_y_q      <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      grid_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      occ_x_q      <= occ_x_d;
      occ_y_q      <= occ_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      grid_full_q  <= grid_full_d;
    end
  end

  assign occ_x      = occ_x_q;
  assign occ_y      = occ_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign grid_full  = grid_full_q;

endmodule

// File: tb/tb_food_placer.sv
// Self-checking bench for food_placer: randomized LFSR streams and occupancy
// maps checked against a rule-level placement model.
`timescale 1ns/1ps
module tb_food_placer;

  localparam int GW    = 10;
  localparam int GH    = 10;
  localparam int MT    = 8;
  localparam int CELLS = GW * GH;
  localparam int SEQ_N = 600;
  localparam int MAXC  = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       place_req;
  logic [3:0] rand_x, rand_y;
  logic [3:0] occ_x, occ_y;
  logic       occ_hit;
  logic [3:0] food_x, food_y;
  logic       food_valid, busy, done, grid_full;

  int total = 0;
  int bad   = 0;
  bit occ_map [CELLS];
  int seq_x [SEQ_N];
  int seq_y [SEQ_N];
  int oob_queries = 0;
  int exp_fx = 0, exp_fy = 0;
  bit exp_valid = 0;

  food_placer #(.MAX_TRIES(MT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .place_req  (place_req),
    .rand_x     (rand_x),
    .rand_y     (rand_y),
    .occ_x      (occ_x),
    .occ_y      (occ_y),
    .occ_hit    (occ_hit),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .busy       (busy),
    .done       (done),
    .grid_full  (grid_full)
  );

  always #5 clk = ~clk;

  // Occupancy map with one cycle of read latency.
  always @(posedge clk)
    occ_hit <= (occ_x < 4'(GW) && occ_y < 4'(GH)) ? occ_map[int'(occ_y) * GW + int'(occ_x)] : 1'b1;

  always @(negedge clk)
    if (rst_n === 1'b1 && (occ_x >= 4'(GW) || occ_y >= 4'(GH))) oob_queries++;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic fill_seq(input int hi);
    for (int i = 0; i < SEQ_N; i++) begin
      seq_x[i] = $urandom_range(0, hi);
      seq_y[i] = $urandom_range(0, hi);
    end
  endtask

  task automatic fill_map(input int pct);
    for (int i = 0; i < CELLS; i++) occ_map[i] = ($urandom_range(0, 99) < pct);
  endtask

  // Walks the placement rules over the stimulus stream; fin is the edge
  // (counted from the request edge) that brings done high.
  task automatic model_place(output int fin, output int fx, output int fy, output bit full);
    int t, tries, s, pos, cx, cy;
    bit scanning;
    t = 1; tries = 0; s = 0; scanning = 0; full = 0; fx = 0; fy = 0; fin = -2; cx = 0; cy = 0;
    while (!scanning) begin
      cx = seq_x[t]; cy = seq_y[t];
      if (cx >= GW || cy >= GH) begin
        tries++;
        if (tries == MT) begin scanning = 1; s = t; end
        else t++;
      end else if (!occ_map[cy * GW + cx]) begin
        fin = t + 2; fx = cx; fy = cy;
        return;
      end else begin
        tries++;
        if (tries == MT) begin scanning = 1; s = t + 2; end
        else t += 3;
      end
    end
    pos = (cy % GH) * GW + (cx % GW);
    for (int k = 0; k < CELLS; k++) begin
      if (!occ_map[pos]) begin
        fin = s + 2 * k + 2; fx = pos % GW; fy = pos / GW;
        return;
      end
      pos = (pos + 1) % CELLS;
    end
    full = 1;
    fin  = s + 2 * CELLS;
  endtask

  task automatic run_place(input bit spam, output int done_edge, output int n_done,
                           output logic busy_first, output logic gfull_first, output logic busy_after);
    done_edge = -1; n_done = 0; busy_first = 1'b0; gfull_first = 1'b1; busy_after = 1'b1;
    @(negedge clk);
    rand_x = 4'(seq_x[0]); rand_y = 4'(seq_y[0]); place_req = 1'b1;
    for (int n = 1; n <= MAXC; n++) begin
      @(negedge clk);
      rand_x = 4'(seq_x[n]); rand_y = 4'(seq_y[n]); place_req = spam;
      @(posedge clk); #1;
      if (n == 1) begin busy_first = busy; gfull_first = grid_full; end
      if (done === 1'b1) begin
        n_done++;
        if (done_edge < 0) done_edge = n;
      end
      if (done_edge >= 0 && n == done_edge + 1) begin
        busy_after = busy;
        break;
      end
    end
    @(negedge clk);
    place_req = 1'b0;
  endtask

  task automatic test_reset();
    int cnt, de, nd, fin, fx, fy;
    logic bf, gf, ba;
    bit full;
    rst_n = 1'b0; place_req = 1'b0; rand_x = '0; rand_y = '0;
    foreach (occ_map[i]) occ_map[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    total++; if (food_valid !== 1'b0 || grid_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_full got=%b%b exp=00", food_valid, grid_full); end
    total++; if ({food_x, food_y, occ_x, occ_y} !== 16'h0) begin bad++; $display("[TB] FAIL reset_coords got=%h exp=0000", {food_x, food_y, occ_x, occ_y}); end
    @(negedge clk); rst_n = 1'b1;
    // Abort a placement while it waits in LOOKUP.
    @(negedge clk); rand_x = 4'd2; rand_y = 4'd5; place_req = 1'b1;
    @(negedge clk); place_req = 1'b0;
    @(posedge clk); #2; rst_n = 1'b0; #1;
    total++; if (busy !== 1'b0 || food_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL reset_abort got busy=%b valid=%b done=%b exp 000", busy, food_valid, done); end
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (done === 1'b1) cnt++; end
    total++; if (cnt !== 0) begin bad++; $display("[TB] FAIL reset_no_done got=%0d exp=0", cnt); end
    exp_fx = 0; exp_fy = 0; exp_valid = 0;
    fill_seq(9);
    model_place(fin, fx, fy, full);
    run_place(1'b0, de, nd, bf, gf, ba);
    total++; if (de !== fin) begin bad++; $display("[TB] FAIL reset_next_done got=%0d exp=%0d", de, fin); end
    total++; if (food_x !== 4'(fx) || food_y !== 4'(fy) || food_valid !== 1'b1) begin bad++; $display("[TB] FAIL reset_next_food got=(%0d,%0d,%b) exp=(%0d,%0d,1)", food_x, food_y, food_valid, fx, fy); end
    exp_fx = fx; exp_fy = fy; exp_valid = 1;
  endtask

  task automatic test_first_try();
    int de, nd, fin, fx, fy;
    logic bf, gf, ba;
    bit full;
    foreach (occ_map[i]) occ_map[i] = 1'b0;
    fill_seq(15);
    seq_x[1] = 3; seq_y[1] = 7;
    model_place(fin, fx, fy, full);
    run_place(1'b0, de, nd, bf, gf, ba);
    total++; if (de !== fin) begin bad++; $display("[TB] FAIL first_done_edge got=%0d exp=%0d", de, fin); end
    total++; if (food_x !== 4'd3 || food_y !== 4'd7) begin bad++; $display("[TB] FAIL first_food got=(%0d,%0d) exp=(3,7)", food_x, food_y); end
    total++; if (food_valid !== 1'b1 || nd !== 1) begin bad++; $display("[TB] FAIL first_valid_ndone got=%b/%0d exp=1/1", food_valid, nd); end
    total++; if (bf !== 1'b1 || ba !== 1'b0) begin bad++; $display("[TB] FAIL first_busy got=%b%b exp=10", bf, ba); end
    exp_fx = 3; exp_fy = 7; exp_valid = 1;
  endtask

  task automatic test_retry();
    int de, nd, fin, fx, fy, a, b, c;
    logic bf, gf, ba;
    bit full;
    foreach (occ_map[i]) occ_map[i] = 1'b0;
    a = $urandom_range(0, CELLS - 1);
    b = (a + 1 + $urandom_range(0, CELLS - 3)) % CELLS;
    c = a;
    while (c == a || c == b) c = $urandom_range(0, CELLS - 1);
    occ_map[a] = 1'b1; occ_map[b] = 1'b1;
    fill_seq(9);
    seq_x[1] = a % GW; seq_y[1] = a / GW;
    seq_x[4] = b % GW; seq_y[4] = b / GW;
    seq_x[7] = c % GW; seq_y[7] = c / GW;
    model_place(fin, fx, fy, full);
    run_place(1'b0, de, nd, bf, gf, ba);
    total++; if (de !== fin) begin bad++; $display("[TB] FAIL retry_done_edge got=%0d exp=%0d", de, fin); end
    total++; if (food_x !== 4'(c % GW) || food_y !== 4'(c / GW)) begin bad++; $display("[TB] FAIL retry_food got=(%0d,%0d) exp=(%0d,%0d)", food_x, food_y, c % GW, c / GW); end
    total++; if (nd !== 1 || food_valid !== 1'b1) begin bad++; $display("[TB] FAIL retry_ndone_valid got=%0d/%b exp=1/1", nd, food_valid); end
    exp_fx = c % GW; exp_fy = c / GW; exp_valid = 1;
  endtask

  task automatic test_scan_last_cell();
    int de, nd, fin, fx, fy;
    logic bf, gf, ba;
    bit full;
    foreach (occ_map[i]) occ_map[i] = 1'b1;
    occ_map[CELLS - 1] = 1'b0;
    fill_seq(9);
    model_place(fin, fx, fy, full);
    run_place(1'b0, de, nd, bf, gf, ba);
    total++; if (de !== fin) begin bad++; $display("[TB] FAIL scan_done_edge got=%0d exp=%0d", de, fin); end
    total++; if (food_x !== 4'd9 || food_y !== 4'd9 || food_valid !== 1'b1) begin bad++; $display("[TB] FAIL scan_food got=(%0d,%0d,%b) exp=(9,9,1)", food_x, food_y, food_valid); end
    total++; if (grid_full !== 1'b0 || nd !== 1) begin bad++; $display("[TB] FAIL scan_full_ndone got=%b/%0d exp=0/1", grid_full, nd); end
    exp_fx = 9; exp_fy = 9; exp_valid = 1;
  endtask

  task automatic test_grid_full();
    int de, nd, fin, fx, fy;
    logic bf, gf, ba;
    bit full;
    foreach (occ_map[i]) occ_map[i] = 1'b1;
    fill_seq(15);
    model_place(fin, fx, fy, full);
    run_place(1'b0, de, nd, bf, gf, ba);
    total++; if (de !== fin) begin bad++; $display("[TB] FAIL full_done_edge got=%0d exp=%0d", de, fin); end
    total++; if (grid_full !== 1'b1 || food_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_flags got full=%b valid=%b exp 1/0", grid_full, food_valid); end
    total++; if (food_x !== 4'(exp_fx) || food_y !== 4'(exp_fy)) begin bad++; $display("[TB] FAIL full_food_kept got=(%0d,%0d) exp=(%0d,%0d)", food_x, food_y, exp_fx, exp_fy); end
    exp_valid = 0;
    // A following request clears grid_full immediately.
    foreach (occ_map[i]) occ_map[i] = 1'b0;
    fill_seq(9);
    model_place(fin, fx, fy, full);
    run_place(1'b0, de, nd, bf, gf, ba);
    total++; if (gf !== 1'b0 || grid_full !== 1'b0) begin bad++; $display("[TB] FAIL full_cleared got=%b%b exp=00", gf, grid_full); end
    total++; if (food_x !== 4'(fx) || food_y !== 4'(fy) || food_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_recover got=(%0d,%0d,%b) exp=(%0d,%0d,1)", food_x, food_y, food_valid, fx, fy); end
    exp_fx = fx; exp_fy = fy; exp_valid = 1;
  endtask

  task automatic test_back_to_back();
    int de, nd, fin, fx, fy, oob0, extra;
    logic bf, gf, ba;
    bit full;
    foreach (occ_map[i]) occ_map[i] = 1'b0;
    fill_seq(9);
    seq_x[1] = 12;
    oob0 = oob_queries;
    model_place(fin, fx, fy, full);
    run_place(1'b1, de, nd, bf, gf, ba);
    extra = 0;
    repeat (8) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
    total++; if (de !== fin) begin bad++; $display("[TB] FAIL b2b_done_edge got=%0d exp=%0d", de, fin); end
    total++; if (nd + extra !== 1) begin bad++; $display("[TB] FAIL b2b_done_count got=%0d exp=1", nd + extra); end
    total++; if (food_x !== 4'(fx) || food_y !== 4'(fy)) begin bad++; $display("[TB] FAIL b2b_food got=(%0d,%0d) exp=(%0d,%0d)", food_x, food_y, fx, fy); end
    total++; if (oob_queries !== oob0) begin bad++; $display("[TB] FAIL b2b_oob_query got=%0d exp=0", oob_queries - oob0); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle got busy=%b exp=0", busy); end
    exp_fx = fx; exp_fy = fy; exp_valid = 1;
  endtask

  task automatic test_random();
    int de, nd, fin, fx, fy, pct;
    logic bf, gf, ba;
    bit full;
    for (int it = 0; it < 25; it++) begin
      case (it % 5)
        0: pct = 0;
        1: pct = $urandom_range(20, 60);
        2: pct = $urandom_range(85, 97);
        3: pct = 99;
        default: pct = 100;
      endcase
      fill_map(pct);
      fill_seq(15);
      model_place(fin, fx, fy, full);
      run_place(1'b0, de, nd, bf, gf, ba);
      if (!full) begin exp_fx = fx; exp_fy = fy; exp_valid = 1; end
      else exp_valid = 0;
      total++; if (de !== fin) begin bad++; $display("[TB] FAIL rand%0d_done_edge got=%0d exp=%0d", it, de, fin); end
      total++; if (food_x !== 4'(exp_fx) || food_y !== 4'(exp_fy)) begin bad++; $display("[TB] FAIL rand%0d_food got=(%0d,%0d) exp=(%0d,%0d)", it, food_x, food_y, exp_fx, exp_fy); end
      total++; if (food_valid !== exp_valid || grid_full !== full) begin bad++; $display("[TB] FAIL rand%0d_flags got valid=%b full=%b exp %b/%b", it, food_valid, grid_full, exp_valid, full); end
      total++; if (nd !== 1 || ba !== 1'b0) begin bad++; $display("[TB] FAIL rand%0d_handshake got ndone=%0d busy_after=%b exp 1/0", it, nd, ba); end
    end
  endtask

  initial begin
    $display("[TB] starting food_placer bench");
    test_reset();
    test_first_try();
    test_retry();
    test_scan_last_cell();
    test_grid_full();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
